y86_mem_stage_p: RTL and testbench
==================================

Name: y86_mem_stage_p

Overview:
- Parametrised successor to the single-cycle Y86-64 Memory stage; sits between the execute and write-back stages of the pipelined core.
- Owns a byte-addressable, little-endian data memory of configurable size.
- Adds configurable access latency with a valid/ready handshake toward execute, and full bounds checking.
- Adds sticky stat/halt handling: after any non-AOK instruction the stage refuses further work until reset.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- MEM_BYTES, 1024, data memory size in bytes; must be ≥ DATA_W/8.
- LATENCY, 1, cycles from acceptance to out_valid for memory-accessing instructions; must be ≥ 1.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  Y86 instruction code.
- valE  in  DATA_W  ALU result / address.
- valA  in  DATA_W  operand / stack address.
- valP  in  DATA_W  next PC (call return address).
- instr_valid  in  1  decode marked the instruction legal.
- imem_error  in  1  fetch address fault.
- out_valid  out  1  one-cycle completion pulse to write-back.
- out_icode  out  4  registered icode.
- out_valE  out  DATA_W  registered valE.
- valM  out  DATA_W  read data; 0 for non-reads.
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS; registered with out_valid.
- halted  out  1  sticky; high once a non-AOK stat has been issued.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: out_valid=0, valM=0, out_icode=0, out_valE=0, stat=AOK, halted=0, in_ready=1.
  - FSM → IDLE.
  - Memory array is zero-initialised at time 0 and is not cleared by reset.
- Access map:
  - Reads: mrmovq(5) at valE; ret(9) at valA; popq(B) at valA.
  - Writes: rmmovq(4) valA→valE; pushq(A) valA→valE; call(8) valP→valE.
  - All other icodes perform no access.
- Data layout: DATA_W/8 bytes, little-endian, at addr..addr+DATA_W/8-1.
- Bounds: dmem_error when addr > MEM_BYTES-DATA_W/8. Use a full-width unsigned compare; no wrap-around, and 0xFFFF_FFFF_FFFF_FFF8 must flag.
- Stat priority, evaluated at acceptance: imem_error→ADR; !instr_valid→INS; dmem_error→ADR; icode==0→HLT; else AOK.
- FSM states:
  - IDLE: in_ready=1. Acceptance occurs on in_valid & in_ready at a rising edge.
    - Memory icode with stat AOK and LATENCY>1 → WAIT, counter=LATENCY-1.
    - Any other case → RESP at the next edge, i.e. 1-cycle latency for non-memory or faulting instructions.
  - WAIT: in_ready=0; counter decrements each edge; at counter==1 → RESP.
  - RESP: out_valid=1 for exactly one cycle, with valM/stat/out_icode/out_valE valid.
    - Writes commit to the array on the edge entering RESP.
    - Reads sample the array on that same edge.
    - in_ready=0 in RESP. Next state is IDLE if stat==AOK, else HALTED.
  - HALTED: halted=1, in_ready=0, out_valid=0; exits only via reset.
- Non-AOK instruction: no write, valM=0, stat reported once.
- LATENCY=1: out_valid is high in the cycle after acceptance.
- Throughput: at most one instruction in flight; accepted-to-accepted spacing is LATENCY+1 cycles.
- in_valid while in_ready=0: ignored. Execute must hold its inputs.
- Reset mid-WAIT: the access is aborted, no write occurs, and no out_valid is issued.
- Inputs are sampled at acceptance only; later changes have no effect on the in-flight instruction.

Test Plan:
- rmmovq icode=4, valE=0x10, valA=0x1122334455667788, then mrmovq icode=5, valE=0x10 → second out_valid has valM=0x1122334455667788, stat=AOK. Byte 0x10 = 0x88.
- mrmovq valE=MEM_BYTES-7 (1017) → stat=ADR, valM=0, halted=1 next cycle, in_ready stays 0. A subsequent in_valid produces no out_valid.
- Fault priority: imem_error=1, instr_valid=0, icode=4, valE=0x20 → stat=ADR. Also check that memory at 0x20 is unchanged, via a reset and re-read.
- Halt handling: icode=0 → stat=HLT, out_valid one pulse, halted=1. Then reset_n pulse → in_ready=1, stat=AOK.
- LATENCY=3 build: call icode=8, valE=0x40, valP=0x312 accepted at edge N → out_valid at edge N+3 only, in_ready=0 for edges N+1..N+3. Then ret icode=9, valA=0x40 → valM=0x312.
- LATENCY=3: pushq to 0x80, reset_n asserted in WAIT → no out_valid. A post-reset read of 0x80 returns 0.

Source files
------------

// File: rtl/y86_mem_stage_p.sv
// Y86-64 memory stage: byte-addressed little-endian data memory with configurable
// access latency, valid/ready intake, bounds checking and a sticky halt after any fault.
module y86_mem_stage_p #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  input  logic              instr_valid,
  input  logic              imem_error,
  output logic              out_valid,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] valM,
  output logic [1:0]        stat,
  output logic              halted
);
  localparam int BYTES = DATA_W / 8;
  localparam int AW    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CW    = $clog2(LATENCY + 1);
  localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(MEM_BYTES - BYTES);

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;
  localparam logic [1:0] ST_ADR = 2'd2;
  localparam logic [1:0] ST_INS = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HALT} state_t;

  function automatic logic is_read(input logic [3:0] ic);
    return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
  endfunction

  function automatic logic is_write(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
  endfunction

  // Memory is not touched by reset; contents survive a reset pulse.
  logic [7:0] mem_q [MEM_BYTES] = '{default: 8'h00};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        p_icode_q, p_icode_d;
  logic [DATA_W-1:0] p_vale_q, p_vale_d;
  logic [DATA_W-1:0] p_addr_q, p_addr_d;
  logic [DATA_W-1:0] p_wdata_q, p_wdata_d;
  logic [1:0]        p_stat_q, p_stat_d;
  logic [3:0]        out_icode_q, out_icode_d;
  logic [DATA_W-1:0] out_vale_q, out_vale_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic [1:0]        stat_q, stat_d;

  logic [DATA_W-1:0] in_addr, in_wdata;
  logic [1:0]        in_stat;
  logic              go_resp;
  logic              from_in;
  logic [3:0]        src_icode;
  logic [DATA_W-1:0] src_vale, src_addr, src_wdata;
  logic [1:0]        src_stat;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  // Decode of the instruction presented by execute; only meaningful at acceptance.
  always_comb begin
    in_addr  = ((icode == 4'h9) || (icode == 4'hB)) ? valA : valE;
    in_wdata = (icode == 4'h8) ? valP : valA;
    if (imem_error)                                                  in_stat = ST_ADR;
    else if (!instr_valid)                                           in_stat = ST_INS;
    else if ((is_read(icode) || is_write(icode)) && in_addr > MAX_ADDR) in_stat = ST_ADR;
    else if (icode == 4'h0)                                          in_stat = ST_HLT;
    else                                                             in_stat = ST_AOK;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_icode_d   = p_icode_q;
    p_vale_d    = p_vale_q;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    p_stat_d    = p_stat_q;
    go_resp     = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        p_icode_d = icode;
        p_vale_d  = valE;
        p_addr_d  = in_addr;
        p_wdata_d = in_wdata;
        p_stat_d  = in_stat;
        if ((is_read(icode) || is_write(icode)) && in_stat == ST_AOK && LATENCY > 1) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end else begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end
      end
      S_WAIT: if (cnt_q == CW'(1)) begin
        state_d = S_RESP;
        go_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      S_RESP:  state_d = (stat_q == ST_AOK) ? S_IDLE : S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // The access happens on the edge entering RESP: straight from the inputs when that
  // is the acceptance edge, otherwise from the copy captured at acceptance.
  always_comb begin
    from_in   = (state_q == S_IDLE);
    src_icode = from_in ? icode    : p_icode_q;
    src_vale  = from_in ? valE     : p_vale_q;
    src_addr  = from_in ? in_addr  : p_addr_q;
    src_wdata = from_in ? in_wdata : p_wdata_q;
    src_stat  = from_in ? in_stat  : p_stat_q;
    mem_addr  = src_addr[AW-1:0];
    mem_we    = go_resp && is_write(src_icode) && (src_stat == ST_AOK);
    rd_data   = '0;
    for (int i = 0; i < BYTES; i++) rd_data[8*i +: 8] = mem_q[mem_addr + AW'(i)];
  end

  always_comb begin
    out_icode_d = out_icode_q;
    out_vale_d  = out_vale_q;
    valm_d      = valm_q;
    stat_d      = stat_q;
    if (go_resp) begin
      out_icode_d = src_icode;
      out_vale_d  = src_vale;
      stat_d      = src_stat;
      valm_d      = (is_read(src_icode) && src_stat == ST_AOK) ? rd_data : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_icode_q   <= '0;
      p_vale_q    <= '0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      p_stat_q    <= ST_AOK;
      out_icode_q <= '0;
      out_vale_q  <= '0;
      valm_q      <= '0;
      stat_q      <= ST_AOK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_icode_q   <= p_icode_d;
      p_vale_q    <= p_vale_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      p_stat_q    <= p_stat_d;
      out_icode_q <= out_icode_d;
      out_vale_q  <= out_vale_d;
      valm_q      <= valm_d;
      stat_q      <= stat_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      for (int i = 0; i < BYTES; i++) mem_q[mem_addr + AW'(i)] <= src_wdata[8*i +: 8];
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign halted    = (state_q == S_HALT);
  assign out_icode = out_icode_q;
  assign out_valE  = out_vale_q;
  assign valM      = valm_q;
  assign stat      = stat_q;
endmodule

// File: tb/tb_y86_mem_stage_p.sv
// Directed bench for y86_mem_stage_p: a LATENCY=1 instance driven from a vector table
// and hand sequences, plus a LATENCY=3 instance for multi-cycle timing and reset abort.
module tb_y86_mem_stage_p;
  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // LATENCY=1 instance
  logic        rst_a, iv_a, rdy_a, ivld_a, imerr_a, ov_a, hlt_a;
  logic [3:0]  ic_a, oic_a;
  logic [63:0] ve_a, va_a, vp_a, ove_a, vm_a;
  logic [1:0]  st_a;

  // LATENCY=3 instance
  logic        rst_b, iv_b, rdy_b, ivld_b, imerr_b, ov_b, hlt_b;
  logic [3:0]  ic_b, oic_b;
  logic [63:0] ve_b, va_b, vp_b, ove_b, vm_b;
  logic [1:0]  st_b;

  y86_mem_stage_p #(.DATA_W(64), .MEM_BYTES(1024), .LATENCY(1)) dut_a (
    .clock(clock), .reset_n(rst_a), .in_valid(iv_a), .in_ready(rdy_a), .icode(ic_a),
    .valE(ve_a), .valA(va_a), .valP(vp_a), .instr_valid(ivld_a), .imem_error(imerr_a),
    .out_valid(ov_a), .out_icode(oic_a), .out_valE(ove_a), .valM(vm_a), .stat(st_a),
    .halted(hlt_a));

  y86_mem_stage_p #(.DATA_W(64), .MEM_BYTES(1024), .LATENCY(3)) dut_b (
    .clock(clock), .reset_n(rst_b), .in_valid(iv_b), .in_ready(rdy_b), .icode(ic_b),
    .valE(ve_b), .valA(va_b), .valP(vp_b), .instr_valid(ivld_b), .imem_error(imerr_b),
    .out_valid(ov_b), .out_icode(oic_b), .out_valE(ove_b), .valM(vm_b), .stat(st_b),
    .halted(hlt_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] vale, vala, valp;
    logic [63:0] exp_valm, exp_vale;
  } vec_t;

  vec_t vecs [9];

  task automatic drive_a(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [63:0] vp, input logic iv, input logic ime);
    iv_a = 1'b1; ic_a = ic; ve_a = ve; va_a = va; vp_a = vp; ivld_a = iv; imerr_a = ime;
  endtask

  task automatic reset_a();
    @(negedge clock); rst_a = 1'b0; iv_a = 1'b0;
    @(negedge clock); rst_a = 1'b1;
  endtask

  // One fault-free instruction on instance A; checks the response and the return to IDLE.
  task automatic run_a(input string nm, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [63:0] vp,
                       input logic [63:0] exp_vm, input logic [63:0] exp_ve);
    @(negedge clock); drive_a(ic, ve, va, vp, 1'b1, 1'b0);
    @(negedge clock); iv_a = 1'b0;
    chk({nm, ".out_valid"}, 64'(ov_a), 64'd1);
    chk({nm, ".valM"}, vm_a, exp_vm);
    chk({nm, ".stat"}, 64'(st_a), 64'd0);
    chk({nm, ".out_icode"}, 64'(oic_a), 64'(ic));
    chk({nm, ".out_valE"}, ove_a, exp_ve);
    chk({nm, ".ready_in_resp"}, 64'(rdy_a), 64'd0);
    @(negedge clock);
    chk({nm, ".pulse_end"}, 64'(ov_a), 64'd0);
    chk({nm, ".ready_back"}, 64'(rdy_a), 64'd1);
  endtask

  // Faulting instruction on instance A; expects a single response then sticky halt.
  task automatic fault_a(input string nm, input logic [3:0] ic, input logic [63:0] ve,
                         input logic iv, input logic ime, input logic [1:0] exp_st);
    @(negedge clock); drive_a(ic, ve, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, iv, ime);
    @(negedge clock);
    chk({nm, ".out_valid"}, 64'(ov_a), 64'd1);
    chk({nm, ".stat"}, 64'(st_a), 64'(exp_st));
    chk({nm, ".valM"}, vm_a, 64'd0);
    @(negedge clock);
    chk({nm, ".halted"}, 64'(hlt_a), 64'd1);
    chk({nm, ".ready_halt"}, 64'(rdy_a), 64'd0);
    chk({nm, ".one_pulse"}, 64'(ov_a), 64'd0);
    iv_a = 1'b0;
  endtask

  task automatic drive_b(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [63:0] vp);
    iv_b = 1'b1; ic_b = ic; ve_b = ve; va_b = va; vp_b = vp; ivld_b = 1'b1; imerr_b = 1'b0;
  endtask

  // Wait on instance B's out_valid with a bounded cycle budget; n = negedges waited.
  task automatic wait_b(input string nm, output int n);
    n = 0;
    while (!ov_b && n < 12) begin @(negedge clock); n++; end
    if (!ov_b) begin
      total++; bad++;
      $display("FAIL %s timeout waiting for out_valid", nm);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{4'h4, 64'h10, 64'h1122334455667788, 64'h0, 64'h0, 64'h10};
    vecs[1] = '{4'h5, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 64'h10};
    vecs[2] = '{4'h5, 64'h11, 64'h0, 64'h0, 64'h0011223344556677, 64'h11};
    vecs[3] = '{4'h5, 64'h0A, 64'h0, 64'h0, 64'h7788000000000000, 64'h0A};
    vecs[4] = '{4'hA, 64'h3F8, 64'hDEADBEEFCAFEF00D, 64'h0, 64'h0, 64'h3F8};
    vecs[5] = '{4'hB, 64'h400, 64'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h400};
    vecs[6] = '{4'h8, 64'h20, 64'h0, 64'h1234, 64'h0, 64'h20};
    vecs[7] = '{4'h9, 64'h99, 64'h20, 64'h0, 64'h1234, 64'h99};
    vecs[8] = '{4'h6, 64'h55, 64'h77, 64'h0, 64'h0, 64'h55};

    rst_a = 1'b0; iv_a = 1'b0; ic_a = '0; ve_a = '0; va_a = '0; vp_a = '0; ivld_a = 1'b1; imerr_a = 1'b0;
    rst_b = 1'b0; iv_b = 1'b0; ic_b = '0; ve_b = '0; va_b = '0; vp_b = '0; ivld_b = 1'b1; imerr_b = 1'b0;
    #12;
    chk("rst.out_valid", 64'(ov_a), 64'd0);
    chk("rst.in_ready", 64'(rdy_a), 64'd1);
    chk("rst.stat", 64'(st_a), 64'd0);
    chk("rst.halted", 64'(hlt_a), 64'd0);
    chk("rst.valM", vm_a, 64'd0);
    chk("rst.out_valE", ove_a, 64'd0);
    @(negedge clock); rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 9; i++)
      run_a($sformatf("vec%0d", i), vecs[i].icode, vecs[i].vale, vecs[i].vala, vecs[i].valp,
            vecs[i].exp_valm, vecs[i].exp_vale);

    // imem_error outranks the illegal-instruction flag; the store must not land.
    fault_a("prio", 4'h4, 64'h20, 1'b0, 1'b1, 2'd2);
    reset_a();
    chk("prio.rst_ready", 64'(rdy_a), 64'd1);
    chk("prio.rst_stat", 64'(st_a), 64'd0);
    run_a("prio.reread", 4'h5, 64'h20, 64'h0, 64'h0, 64'h1234, 64'h20);

    fault_a("ins", 4'h6, 64'h0, 1'b0, 1'b0, 2'd3);
    reset_a();

    fault_a("hlt", 4'h0, 64'h0, 1'b1, 1'b0, 2'd1);
    reset_a();
    chk("hlt.rst_ready", 64'(rdy_a), 64'd1);
    chk("hlt.rst_stat", 64'(st_a), 64'd0);
    chk("hlt.rst_halted", 64'(hlt_a), 64'd0);

    // One byte past the last legal word start, then attempts while halted.
    fault_a("bound", 4'h5, 64'd1017, 1'b1, 1'b0, 2'd2);
    @(negedge clock); drive_a(4'h5, 64'h10, 64'h0, 64'h0, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clock); if (ov_a) n++; end
    chk("bound.ignored_pulses", 64'(n), 64'd0);
    chk("bound.still_ready0", 64'(rdy_a), 64'd0);
    reset_a();

    fault_a("hiaddr", 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 2'd2);
    reset_a();

    // LATENCY=3: accept at edge N, response visible only across edge N+3.
    @(negedge clock); drive_b(4'h8, 64'h40, 64'h0, 64'h312);
    @(negedge clock); iv_b = 1'b0; vp_b = 64'hBAD; ve_b = 64'h999;
    chk("l3.c1.out_valid", 64'(ov_b), 64'd0);
    chk("l3.c1.ready", 64'(rdy_b), 64'd0);
    @(negedge clock);
    chk("l3.c2.out_valid", 64'(ov_b), 64'd0);
    chk("l3.c2.ready", 64'(rdy_b), 64'd0);
    @(negedge clock);
    chk("l3.c3.out_valid", 64'(ov_b), 64'd1);
    chk("l3.c3.ready", 64'(rdy_b), 64'd0);
    chk("l3.c3.stat", 64'(st_b), 64'd0);
    chk("l3.c3.out_valE", ove_b, 64'h40);
    @(negedge clock);
    chk("l3.c4.out_valid", 64'(ov_b), 64'd0);
    chk("l3.c4.ready", 64'(rdy_b), 64'd1);

    drive_b(4'h9, 64'h0, 64'h40, 64'h0);
    @(negedge clock); iv_b = 1'b0;
    wait_b("l3.ret", n);
    chk("l3.ret.latency", 64'(n), 64'd2);
    chk("l3.ret.valM", vm_b, 64'h312);
    @(negedge clock);

    // Reset while the push is still waiting: nothing may be written or reported.
    drive_b(4'hA, 64'h80, 64'hAAAA_5555_1234_5678, 64'h0);
    @(negedge clock); iv_b = 1'b0; rst_b = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clock); if (ov_b) n++; end
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clock); if (ov_b) n++; end
    chk("l3.abort.no_pulse", 64'(n), 64'd0);
    chk("l3.abort.ready", 64'(rdy_b), 64'd1);
    drive_b(4'h5, 64'h80, 64'h0, 64'h0);
    @(negedge clock); iv_b = 1'b0;
    wait_b("l3.reread", n);
    chk("l3.reread.valM", vm_b, 64'h0);
    chk("l3.reread.stat", 64'(st_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
